// File: rtl/mismatch_scoreboard.sv
// mismatch_scoreboard
// Response checker for the consuming end of a stimulus/compare flow. It counts
// accepted samples and mismatching samples, timestamps the first mismatch in
// RUN cycles, and exposes the report once the run has stopped.
// Optional feature macro: SCOREBOARD_PER_OUTPUT_EN adds one saturating error
// counter per compared output, read back through rd_idx/rd_errors.
module mismatch_scoreboard #(
    parameter int WIDTH = 3,
    parameter int CW    = 32,
    localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] ref_vec,
    input  logic [WIDTH-1:0] dut_vec,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [CW-1:0]    total_samples,
    output logic [CW-1:0]    total_errors,
    output logic             first_err_valid,
    output logic [CW-1:0]    first_err_cycle,
    input  logic [IW-1:0]    rd_idx,
    output logic [CW-1:0]    rd_errors
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counters stick at all-ones instead of wrapping to zero.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : (v + {{(CW-1){1'b0}}, 1'b1});
    endfunction

    logic [1:0]       state_q,    state_d;
    logic [CW-1:0]    cycle_q,    cycle_d;
    logic [CW-1:0]    samples_q,  samples_d;
    logic [CW-1:0]    errors_q,   errors_d;
    logic             mismatch_q, mismatch_d;
    logic             fev_q,      fev_d;
    logic [CW-1:0]    fec_q,      fec_d;

    logic             in_run;
    logic             clear;
    logic             accept;
    logic [WIDTH-1:0] err_bits;

    // Any non-RUN state (including an unreachable encoding) may launch a run;
    // start wins over a simultaneous stop there because stop is only looked
    // at in RUN.
    assign in_run   = (state_q == ST_RUN);
    assign clear    = !in_run && start;
    assign accept   = in_run && sample_valid;
    assign err_bits = ref_vec ^ dut_vec;

    // Next-state logic for the FSM and the shared run report.
    always_comb begin
        state_d    = state_q;
        cycle_d    = cycle_q;
        samples_d  = samples_q;
        errors_d   = errors_q;
        mismatch_d = mismatch_q;
        fev_d      = fev_q;
        fec_d      = fec_q;

        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (stop)  state_d = ST_DONE;
            ST_DONE: if (start) state_d = ST_RUN;
            default: state_d = start ? ST_RUN : ST_IDLE;
        endcase

        if (clear) begin
            cycle_d    = '0;
            samples_d  = '0;
            errors_d   = '0;
            mismatch_d = 1'b0;
            fev_d      = 1'b0;
            fec_d      = '0;
        end else if (in_run) begin
            // cycle_q is the index of the current RUN cycle, so it is the
            // timestamp for a mismatch seen now; it advances valid or not.
            cycle_d = sat_inc(cycle_q);
            if (accept) begin
                samples_d  = sat_inc(samples_q);
                mismatch_d = |err_bits;
                if (|err_bits) begin
                    errors_d = sat_inc(errors_q);
                    if (!fev_q) begin
                        fev_d = 1'b1;
                        fec_d = cycle_q;
                    end
                end
            end
        end
    end

    // State and report registers; reset discards any partial report.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cycle_q    <= '0;
            samples_q  <= '0;
            errors_q   <= '0;
            mismatch_q <= 1'b0;
            fev_q      <= 1'b0;
            fec_q      <= '0;
        end else begin
            state_q    <= state_d;
            cycle_q    <= cycle_d;
            samples_q  <= samples_d;
            errors_q   <= errors_d;
            mismatch_q <= mismatch_d;
            fev_q      <= fev_d;
            fec_q      <= fec_d;
        end
    end

    assign busy            = (state_q == ST_RUN);
    assign done            = (state_q == ST_DONE);
    assign mismatch        = mismatch_q;
    assign total_samples   = samples_q;
    assign total_errors    = errors_q;
    assign first_err_valid = fev_q;
    assign first_err_cycle = fec_q;

`ifdef SCOREBOARD_PER_OUTPUT_EN
    logic [CW-1:0] err_cnt_q [WIDTH];
    logic [CW-1:0] err_cnt_d [WIDTH];

    // Each set bit of err_bits charges one error to its own output.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clear) begin
            for (int i = 0; i < WIDTH; i++) err_cnt_d[i] = '0;
        end else if (accept) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (err_bits[i]) err_cnt_d[i] = sat_inc(err_cnt_q[i]);
            end
        end
    end

    // Per-output counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) err_cnt_q[i] <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    // Out-of-range selects read as zero rather than aliasing a real output.
    always_comb begin
        rd_errors = '0;
        if (int'(rd_idx) < WIDTH) rd_errors = err_cnt_q[rd_idx];
    end
`else
    logic unused_rd_idx;
    assign unused_rd_idx = ^rd_idx;
    assign rd_errors     = '0;
`endif

endmodule

// File: tb/tb_mismatch_scoreboard.sv
// Self-checking bench for mismatch_scoreboard. Two instances (CW=32 and CW=4)
// share one stimulus stream; a run-level model keeps unbounded counts and the
// expected outputs are those counts clipped to each instance's counter range.
module tb_mismatch_scoreboard;

    localparam int W = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       sample_valid = 1'b0;
    logic [2:0] ref_vec = '0;
    logic [2:0] dut_vec = '0;
    logic [1:0] rd_idx = '0;

    logic        busy, done, mismatch, fev;
    logic [31:0] tsamp, terr, fec, rderr;
    logic        busy4, done4, mismatch4, fev4;
    logic [3:0]  tsamp4, terr4, fec4, rderr4;

    mismatch_scoreboard #(.WIDTH(W), .CW(32)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .sample_valid(sample_valid), .ref_vec(ref_vec), .dut_vec(dut_vec),
        .busy(busy), .done(done), .mismatch(mismatch),
        .total_samples(tsamp), .total_errors(terr),
        .first_err_valid(fev), .first_err_cycle(fec),
        .rd_idx(rd_idx), .rd_errors(rderr));

    mismatch_scoreboard #(.WIDTH(W), .CW(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .sample_valid(sample_valid), .ref_vec(ref_vec), .dut_vec(dut_vec),
        .busy(busy4), .done(done4), .mismatch(mismatch4),
        .total_samples(tsamp4), .total_errors(terr4),
        .first_err_valid(fev4), .first_err_cycle(fec4),
        .rd_idx(rd_idx), .rd_errors(rderr4));

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 0;

    // Run-level model: 0 idle, 1 running, 2 stopped.
    int     m_state = 0;
    longint m_samples = 0, m_errors = 0, m_cyc = 0, m_fec = 0;
    bit     m_mis = 0, m_fev = 0;
    longint m_pe [W];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic longint clip(input longint v, input int cw);
        longint mx;
        mx = (longint'(1) << cw) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic longint exp_rd(input int idx, input int cw);
`ifdef SCOREBOARD_PER_OUTPUT_EN
        if (idx < W) return clip(m_pe[idx], cw);
        return 0;
`else
        return 0;
`endif
    endfunction

    // Model update from the inputs present at each rising edge.
    always @(posedge clk) begin
        if (reset) begin
            m_state = 0; m_samples = 0; m_errors = 0; m_cyc = 0;
            m_fec = 0; m_mis = 0; m_fev = 0;
            for (int i = 0; i < W; i++) m_pe[i] = 0;
        end else if (m_state != 1) begin
            if (start) begin
                m_state = 1; m_samples = 0; m_errors = 0; m_cyc = 0;
                m_fec = 0; m_mis = 0; m_fev = 0;
                for (int i = 0; i < W; i++) m_pe[i] = 0;
            end
        end else begin
            if (sample_valid) begin
                logic [2:0] e;
                e = ref_vec ^ dut_vec;
                m_samples++;
                m_mis = (e != 0);
                if (e != 0) begin
                    m_errors++;
                    if (!m_fev) begin m_fev = 1; m_fec = m_cyc; end
                end
                for (int i = 0; i < W; i++) if (e[i]) m_pe[i]++;
            end
            m_cyc++;
            if (stop) m_state = 2;
        end
    end

    // Compare both instances against the model every cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy",       busy,     m_state == 1);
            chk("done",       done,     m_state == 2);
            chk("mismatch",   mismatch, m_mis);
            chk("samples",    tsamp,    clip(m_samples, 32));
            chk("errors",     terr,     clip(m_errors, 32));
            chk("fev",        fev,      m_fev);
            chk("fec",        fec,      clip(m_fec, 32));
            chk("rd_errors",  rderr,    exp_rd(int'(rd_idx), 32));
            chk("busy4",      busy4,    m_state == 1);
            chk("done4",      done4,    m_state == 2);
            chk("mismatch4",  mismatch4, m_mis);
            chk("samples4",   tsamp4,   clip(m_samples, 4));
            chk("errors4",    terr4,    clip(m_errors, 4));
            chk("fev4",       fev4,     m_fev);
            chk("fec4",       fec4,     clip(m_fec, 4));
            chk("rd_errors4", rderr4,   exp_rd(int'(rd_idx), 4));
        end
    end

    task automatic step(input logic s, input logic p, input logic v,
                        input logic [2:0] r, input logic [2:0] d, input logic rs);
        start = s; stop = p; sample_valid = v; ref_vec = r; dut_vec = d;
        reset = rs;
        rd_idx = 2'($urandom_range(0, 3));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        step(0, 0, 0, 3'b000, 3'b000, 0);
    endtask

    task automatic pin_rd(input int idx, input longint exp);
        rd_idx = 2'(idx);
        #1;
`ifdef SCOREBOARD_PER_OUTPUT_EN
        chk($sformatf("pin_rd%0d", idx), rderr, exp);
`else
        chk($sformatf("pin_rd%0d", idx), rderr, 0 * exp);
`endif
    endtask

    initial begin
        logic [2:0] v3;
        @(posedge clk); #1;
        step(0, 0, 0, 0, 0, 1);
        cmp_en = 1;
        chk("pin_reset_busy", busy, 0);
        chk("pin_reset_samples", tsamp, 0);

        // 10 matching samples, then stop
        step(1, 0, 0, 0, 0, 0);
        chk("pin_busy_after_start", busy, 1);
        for (int i = 0; i < 10; i++) begin
            v3 = 3'($urandom);
            step(0, 0, 1, v3, v3, 0);
        end
        step(0, 1, 0, 0, 0, 0);
        chk("pin_done", done, 1);
        chk("pin_samples10", tsamp, 10);
        chk("pin_errors0", terr, 0);
        chk("pin_fev0", fev, 0);

        // first mismatch on RUN cycle 2
        step(1, 0, 0, 0, 0, 0);
        idle_cycle();
        idle_cycle();
        step(0, 0, 1, 3'b101, 3'b100, 0);
        chk("pin_fec2", fec, 2);
        chk("pin_err1", terr, 1);
        chk("pin_mis1", mismatch, 1);
        pin_rd(0, 1);
        step(0, 0, 1, 3'b010, 3'b010, 0);
        chk("pin_mis0", mismatch, 0);
        step(0, 1, 0, 0, 0, 0);

        // three mismatches in a fresh run
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 3'b000, 3'b011, 0);
        step(0, 0, 1, 3'b111, 3'b101, 0);
        step(0, 0, 1, 3'b110, 3'b000, 0);
        chk("pin_err3", terr, 3);
        chk("pin_fec0", fec, 0);
        pin_rd(0, 1);
        pin_rd(1, 3);
        pin_rd(2, 1);
        pin_rd(3, 0);

        // stop together with a mismatching sample, then restart from DONE
        step(0, 1, 1, 3'b111, 3'b000, 0);
        chk("pin_err4", terr, 4);
        chk("pin_done_stop", done, 1);
        step(1, 1, 0, 0, 0, 0);
        chk("pin_restart_busy", busy, 1);
        chk("pin_restart_samples", tsamp, 0);
        chk("pin_restart_fev", fev, 0);

        // saturation in the 4-bit instance
        for (int i = 0; i < 20; i++) step(0, 0, 1, 3'b001, 3'b000, 0);
        chk("pin_sat_samples4", tsamp4, 15);
        chk("pin_sat_errors4", terr4, 15);
        chk("pin_nosat_samples", tsamp, 20);
        step(0, 1, 0, 0, 0, 0);

        // reset mid-run
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 3'b100, 3'b000, 0);
        step(0, 0, 1, 3'b100, 3'b000, 1);
        chk("pin_rst_busy", busy, 0);
        chk("pin_rst_samples", tsamp, 0);
        chk("pin_rst_errors", terr, 0);
        step(0, 0, 1, 3'b111, 3'b000, 0);
        chk("pin_idle_samples", tsamp, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic s, p, v, rs;
            s  = ($urandom_range(0, 3) == 0);
            p  = ($urandom_range(0, 40) == 0);
            v  = ($urandom_range(0, 3) != 0);
            rs = ($urandom_range(0, 400) == 0);
            v3 = 3'($urandom);
            if ($urandom_range(0, 2) == 0) step(s, p, v, v3, 3'($urandom), rs);
            else step(s, p, v, v3, v3, rs);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mismatch_scoreboard.md
# mismatch_scoreboard

Synthesizable response checker that sits on the consuming end of the stimulus/compare flow. Each cycle it takes a reference output vector and a DUT output vector, and counts samples and mismatching samples. It records the cycle of the first mismatch and, optionally, keeps per-output error counts. The counts are exposed as a run report once a run is stopped, which lets the hardware-side harness produce the same summary the simulation bench prints.

## Interface
- WIDTH, 3: number of compared output bits (one bit per DUT output).
- CW, 32: width of every counter and timestamp.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  begin a run (accepted in IDLE or DONE).
- stop  in  1  end a run (accepted in RUN).
- sample_valid  in  1  the ref_vec/dut_vec pair is a sample this cycle.
- ref_vec  in  WIDTH  golden outputs.
- dut_vec  in  WIDTH  DUT outputs.
- busy  out  1  high in RUN.
- done  out  1  high in DONE; the report is stable.
- mismatch  out  1  registered flag: the previous accepted sample mismatched.
- total_samples  out  CW  accepted samples.
- total_errors  out  CW  accepted samples with ref_vec != dut_vec.
- first_err_valid  out  1  at least one mismatch has been recorded.
- first_err_cycle  out  CW  RUN-cycle index of the first mismatch.
- rd_idx  in  clog2(WIDTH) (min 1)  per-output report select.
- rd_errors  out  CW  error count of output rd_idx (only with the macro).

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE + start goes to RUN. DONE + start goes to RUN. On either transition all counters, first_err_*, and mismatch clear in the same edge.
- In RUN, start is ignored. When stop is high the FSM goes to DONE. When stop and sample_valid are both high, the sample is still counted.
- In IDLE and DONE, sample_valid is ignored and the report holds.
- cycle_cnt is internal. It is 0 on the first RUN cycle and increments every RUN cycle, valid or not.
- An accepted sample has these effects:
  - total_samples increments.
  - err_bits = ref_vec ^ dut_vec.
  - If err_bits is nonzero: total_errors increments, and mismatch is 1 (otherwise 0).
  - If err_bits is nonzero and first_err_valid is 0: first_err_cycle = cycle_cnt and first_err_valid = 1.
  - For each set bit i of err_bits, err_cnt[i] increments (only with the macro).
- All counters saturate at 2^CW-1 and never wrap. cycle_cnt also saturates.
- rd_errors is combinational from the err_cnt array. An rd_idx of WIDTH or more returns 0.

## Timing
- Reset values: busy=0, done=0, mismatch=0, all counts 0, first_err_valid=0, first_err_cycle=0.
- Latency is 1 cycle: a sample accepted at edge n is reflected in every output after edge n.
- done rises on the edge after stop is accepted. done holds until start or reset.
- busy rises on the edge after start is accepted.
- Reset asserted mid-run returns the block to IDLE on that edge. The partial report is discarded.
- When start and stop are asserted together in IDLE or DONE, only start is honoured.

## Configuration
- SCOREBOARD_PER_OUTPUT_EN
  - Defined: the WIDTH×CW err_cnt array and rd_errors are implemented.
  - Undefined: no per-output counters are built, rd_errors is tied to 0, and rd_idx is unused. All other behaviour is identical.

## Test plan
- Reset, then start. Give 10 valid samples with ref_vec == dut_vec, then stop. Expect total_samples=10, total_errors=0, first_err_valid=0, done=1 on the edge after stop.
- Start. Hold sample_valid low for 2 cycles, then give a mismatching sample (ref=3'b101, dut=3'b100) on RUN cycle 2. Expect first_err_cycle=2, total_errors=1, mismatch=1 for one cycle. With the macro, rd_idx=0 gives rd_errors=1.
- Give 3 mismatches with err_bits 3'b011, 3'b010, and 3'b110. Expect total_errors=3 and first_err_cycle equal to the first one's cycle. With the macro, per-output counts are [1,3,1] for bits 0..2.
- Assert stop together with a mismatching sample. Expect the sample counted (total_errors incremented), then DONE. A start in DONE clears everything on the next edge.
- Build with CW=4 and give 20 mismatching samples. Expect total_samples=15 and total_errors=15 (saturated), with no wrap.
- Assert reset after 5 samples in RUN. Expect IDLE with all outputs 0 on the next edge. sample_valid in IDLE leaves total_samples at 0.
